// File: rtl/popcount_pkg.sv
// popcount_pkg: FSM state encoding and sum-width helper shared by the popcount accumulator.
package popcount_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  function automatic int sum_width(input int width, input int beats);
    return $clog2(width * beats + 1);
  endfunction
endpackage

// File: rtl/popcount_word.sv
// popcount_word: combinational set-bit count of one word.
// POPCOUNT_APPROX_EN forces bit 0 of the count to zero (truncated approximate count).
module popcount_word #(
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] exact;
  always_comb begin
    exact = '0;
    for (int i = 0; i < WIDTH; i++) exact = exact + CNT_W'(data_i[i]);
  end
`ifdef POPCOUNT_APPROX_EN
  assign cnt_o = exact & ~CNT_W'(1);
`else
  assign cnt_o = exact;
`endif
endmodule

// File: rtl/popcount_accum.sv
// popcount_accum: accumulates per-word popcounts over a frame and presents a held result with threshold fire.
// Build option POPCOUNT_APPROX_EN (in popcount_word) selects truncated beat counts.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MAX_BEATS = 4,
  parameter int SUM_W     = sum_width(WIDTH, MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [SUM_W-1:0] thr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_fire,
  output logic             out_ovf
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int PC_W  = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d, sum_q, beat;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0] pc;
  logic fire_q, ovf_q, accept, close;
  popcount_word #(.WIDTH(WIDTH), .CNT_W(PC_W)) u_word (.data_i(in_data), .cnt_o(pc));
  // a word accepted in IDLE starts a fresh frame, so the stale acc/cnt are ignored there
  always_comb begin
    beat    = SUM_W'(pc);
    accept  = in_valid && state_q != HOLD;
    acc_d   = (state_q == IDLE ? '0 : acc_q) + beat;
    cnt_d   = (state_q == IDLE ? '0 : cnt_q) + CNT_W'(1);
    close   = accept && (in_last || cnt_d == CNT_W'(MAX_BEATS));
    state_d = state_q == HOLD ? (out_ready ? IDLE : HOLD) : close ? HOLD : accept ? ACCUM : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      fire_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
      if (close) begin
        sum_q  <= acc_d;
        fire_q <= acc_d >= thr;
        ovf_q  <= !in_last;
      end
    end
  end
  assign in_ready  = state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign out_sum   = sum_q;
  assign out_fire  = fire_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: directed scoreboard bench for popcount_accum (WIDTH=10, MAX_BEATS=4).
module tb_popcount_accum;
  typedef struct packed {
    logic [5:0] sum;
    logic       fire;
    logic       ovf;
  } exp_t;
  logic clk, rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_fire, out_ovf;
  logic [9:0] in_data;
  logic [5:0] thr, out_sum;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int x0;
  logic [5:0] acc_m, last_sum;
  int beats_m;
  popcount_accum #(.WIDTH(10), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .thr(thr), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_fire(out_fire), .out_ovf(out_ovf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && out_valid && out_ready) xfers <= xfers + 1;
  function automatic logic [5:0] pcm(input logic [9:0] d);
    logic [5:0] c = '0;
    for (int i = 0; i < 10; i++) c = c + 6'(d[i]);
`ifdef POPCOUNT_APPROX_EN
    c[0] = 1'b0;
`endif
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // drive one word at a negedge; the model closes the frame on last or the 4th beat
  task automatic send(input logic [9:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    chk("in_ready_before_send", in_ready, 1);
    acc_m = (beats_m == 0) ? pcm(d) : acc_m + pcm(d);
    beats_m++;
    if (l || beats_m == 4) begin
      q.push_back('{sum: acc_m, fire: acc_m >= thr, ovf: !l});
      last_sum = acc_m;
      beats_m  = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic collect(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_q_nonempty"}, q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_sum"}, out_sum, e.sum);
      chk({tag, "_fire"}, out_fire, e.fire);
      chk({tag, "_ovf"}, out_ovf, e.ovf);
    end
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1; thr = 6'd5;
    acc_m = '0; beats_m = 0; last_sum = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_fire", out_fire, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    // single full word with last
    send(10'h3FF, 1'b1);
    chk("t1_latency", out_valid, 1);
    collect("t1");
    @(negedge clk);
    chk("t1_valid_drop", out_valid, 0);
    // three beats with gaps
    thr = 6'd7;
    send(10'h001, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_gap_sum", out_sum, last_sum);
    chk("t2_gap_valid", out_valid, 0);
    send(10'h003, 1'b0);
    @(negedge clk);
    chk("t2_gap2_sum", out_sum, last_sum);
    send(10'h007, 1'b1);
    collect("t2");
    @(negedge clk);
    // force-close at MAX_BEATS
    thr = 6'd20;
    send(10'h3FF, 1'b0);
    send(10'h3FF, 1'b0);
    send(10'h3FF, 1'b0);
    out_ready = 1'b0;
    send(10'h3FF, 1'b0);
    in_valid = 1'b1; in_data = 10'h3FF;
    chk("t3_fifth_ready", in_ready, 0);
    @(negedge clk);
    chk("t3_fifth_sum", out_sum, 40);
    in_valid = 1'b0;
    collect("t3");
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", out_valid, 0);
    // backpressure with thr toggling and words offered during HOLD
    thr = 6'd5;
    out_ready = 1'b0;
    send(10'h00F, 1'b1);
    x0 = xfers;
    in_valid = 1'b1; in_data = 10'h3FF; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      thr = (i % 2 == 0) ? 6'd0 : 6'd63;
      chk("t4_hold_ready", in_ready, 0);
      chk("t4_hold_sum", out_sum, 4);
      chk("t4_hold_fire", out_fire, 0);
      @(negedge clk);
    end
    thr = 6'd5;
    collect("t4");
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_one_xfer", xfers - x0, 1);
    chk("t4_valid_drop", out_valid, 0);
    send(10'h001, 1'b1);
    collect("t4b");
    @(negedge clk);
    // reset mid-frame discards the partial sum
    send(10'h3FF, 1'b0);
    send(10'h3FF, 1'b0);
    x0 = xfers;
    rst_n = 1'b0;
    acc_m = '0; beats_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sum", out_sum, 0);
    chk("t5_rst_ready", in_ready, 1);
    send(10'h00F, 1'b1);
    collect("t5");
    @(negedge clk);
    chk("t5_one_xfer", xfers - x0, 1);
    // approximate-count frame (exact build yields 4, approx build yields 2)
    thr = 6'd2;
    send(10'h007, 1'b0);
    send(10'h001, 1'b1);
    collect("t6");
    @(negedge clk);
    chk("q_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
